// File: rtl/muldiv_pkg.sv
// Shared types, constants and op-decoding helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN           = 32;
    localparam int ITER           = 32;
    localparam int MULDIV_LATENCY = 33;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    // Handshake: start is taken only while busy=0 and kill=0; the requester holds the
    // instruction until done, which pulses for one cycle with result/rd_out/wb_enable valid.
    logic                start;
    logic [2:0]          op;
    logic [XLEN-1:0]     op_a;
    logic [XLEN-1:0]     op_b;
    logic [4:0]          rd_in;
    logic                kill;
    logic                busy;
    logic                done;
    logic [XLEN-1:0]     result;
    logic [4:0]          rd_out;
    logic                wb_enable;
    state_e              dbg_state;

    modport master (
        output start, op, op_a, op_b, rd_in, kill,
        input  busy, done, result, rd_out, wb_enable, dbg_state
    );

    modport slave (
        input  start, op, op_a, op_b, rd_in, kill,
        output busy, done, result, rd_out, wb_enable, dbg_state
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath on operand magnitudes: shift-add multiply or restoring divide.
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            mode,     // 1 = divide, 0 = multiply
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        if (load) begin
            hi_d = '0;
            lo_d = a_mag;
            b_d  = b_mag;
        end else if (step) begin
            if (mode) begin
                // shifted < 2*b, so a borrow shows up in the top bit of diff
                if (!diff[XLEN]) begin
                    hi_d = diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = shifted[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[XLEN:1];
                lo_d = {sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: FSM, sign handling, divide-by-zero override and handshake around the iterative core.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    op_e             op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic            neg_q, neg_d;
    logic            div_zero_q, div_zero_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    op_e             op_in;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            load, step;
    logic [XLEN-1:0] acc_hi, acc_lo;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quot_s, rem_s, final_res;

    assign op_in = op_e'(bus.op);

    always_comb begin
        a_neg = a_signed(op_in) && bus.op_a[XLEN-1];
        b_neg = b_signed(op_in) && bus.op_b[XLEN-1];
        a_mag = a_neg ? -bus.op_a : bus.op_a;
        b_mag = b_neg ? -bus.op_b : bus.op_b;
    end

    muldiv_iter_core u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .mode  (is_div(op_q)),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .hi    (acc_hi),
        .lo    (acc_lo)
    );

    // Signed fix-up applied on the way into DONE
    always_comb begin
        prod_s = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quot_s = div_zero_q ? '1 : (neg_q ? -acc_lo : acc_lo);
        rem_s  = neg_q ? -acc_hi : acc_hi;
        case (op_q)
            OP_MUL:                        final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_res = quot_s;
            default:                       final_res = rem_s;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        rd_d       = rd_q;
        neg_d      = neg_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        result_d   = result_q;
        load       = 1'b0;
        step       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.kill) begin
                    state_d    = BUSY;
                    load       = 1'b1;
                    count_d    = CNT_W'(ITER);
                    op_d       = op_in;
                    rd_d       = bus.rd_in;
                    neg_d      = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
                    div_zero_d = is_div(op_in) && (bus.op_b == '0);
                end
            end
            BUSY: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else if (count_q != '0) begin
                    step    = 1'b1;
                    count_d = count_q - 1'b1;
                end else begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = final_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= OP_MUL;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            neg_q      <= neg_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q && !bus.kill;
    assign bus.wb_enable = bus.done && (rd_q != 5'd0);
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus handshake, kill and reset sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    muldiv_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.rd_in = rd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic [31:0] res, output logic [4:0] rdo,
                             output logic wb);
        lat = -1;
        res = '0;
        rdo = '0;
        wb  = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                res = bus.result;
                rdo = bus.rd_out;
                wb  = bus.wb_enable;
                break;
            end
        end
    endtask

    task automatic watch_no_done(input int cycles, output int seen);
        seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        wb;
        int          seen;
        int          dones;
        logic        busy_ok;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd12, 32'd2};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         5'd14, 32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0};
        vecs[12] = '{3'd0, 32'd3,         32'd4,         5'd0,  32'd12};
        vecs[13] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFFF};
        vecs[14] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFF9};
        vecs[15] = '{3'd3, 32'hFFFF_FFFF, 32'd2,         5'd31, 32'd1};

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.rd_in = '0;
        bus.kill  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy",   32'(bus.busy),      32'd0);
        check("reset_done",   32'(bus.done),      32'd0);
        check("reset_wb",     32'(bus.wb_enable), 32'd0);
        check("reset_result", bus.result,         32'd0);
        check("reset_rd",     32'(bus.rd_out),    32'd0);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
            wait_done(lat, res, rdo, wb);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(MULDIV_LATENCY));
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
            check($sformatf("v%0d_rd_out", i), 32'(rdo), 32'(vecs[i].rd));
            check($sformatf("v%0d_wb", i), 32'(wb), 32'(vecs[i].rd != 5'd0));
        end

        // start pulses while busy must be ignored
        issue(3'd0, 32'd3, 32'd4, 5'd9);
        dones   = 0;
        busy_ok = 1'b1;
        lat     = -1;
        res     = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            bus.start = (n == 5 || n == 20);
            bus.op    = 3'd4;
            bus.op_a  = 32'd100;
            bus.op_b  = 32'd7;
            bus.rd_in = 5'd3;
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    res = bus.result;
                end
            end
            if (lat < 0 && !bus.busy) busy_ok = 1'b0;
        end
        bus.start = 1'b0;
        check("ignore_latency", 32'(lat), 32'(MULDIV_LATENCY));
        check("ignore_result",  res, 32'd12);
        check("ignore_dones",   32'(dones), 32'd1);
        check("ignore_busy",    32'(busy_ok), 32'd1);

        // kill in BUSY
        issue(3'd0, 32'd3, 32'd4, 5'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        check("kill_cycle_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check("kill_idle_busy", 32'(bus.busy), 32'd0);
        check("kill_state", 32'(bus.dbg_state), 32'(IDLE));
        watch_no_done(45, seen);
        check("kill_no_done", 32'(seen), 32'd0);
        issue(3'd0, 32'd6, 32'd7, 5'd4);
        wait_done(lat, res, rdo, wb);
        check("after_kill_latency", 32'(lat), 32'(MULDIV_LATENCY));
        check("after_kill_result", res, 32'd42);

        // reset mid-operation
        issue(3'd0, 32'd5, 32'd5, 5'd4);
        repeat (15) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy",   32'(bus.busy),      32'd0);
        check("midrst_done",   32'(bus.done),      32'd0);
        check("midrst_wb",     32'(bus.wb_enable), 32'd0);
        check("midrst_result", bus.result,         32'd0);
        check("midrst_rd",     32'(bus.rd_out),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        watch_no_done(45, seen);
        check("midrst_no_done", 32'(seen), 32'd0);
        issue(3'd5, 32'd100, 32'd7, 5'd21);
        wait_done(lat, res, rdo, wb);
        check("after_rst_latency", 32'(lat), 32'(MULDIV_LATENCY));
        check("after_rst_result", res, 32'd14);
        check("after_rst_rd", 32'(rdo), 32'd21);

        // kill during the done cycle masks done and wb_enable
        issue(3'd0, 32'd2, 32'd9, 5'd7);
        wait_done(lat, res, rdo, wb);
        check("killdone_latency", 32'(lat), 32'(MULDIV_LATENCY));
        bus.kill = 1'b1;
        #1;
        check("killdone_done", 32'(bus.done), 32'd0);
        check("killdone_wb", 32'(bus.wb_enable), 32'd0);
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check("killdone_idle", 32'(bus.busy), 32'd0);

        // kill together with start in IDLE suppresses the accept
        @(negedge clk);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        bus.op    = 3'd0;
        bus.op_a  = 32'd1;
        bus.op_b  = 32'd1;
        bus.rd_in = 5'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        check("kill_start_busy", 32'(bus.busy), 32'd0);
        watch_no_done(40, seen);
        check("kill_start_no_done", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit that consumes the two register-file read operands and the destination index for M-extension instructions.
- Produces a 32-bit result plus a write-back enable and index for the register-file write port.
- Fixed-latency, one operation in flight, start/done handshake; the pipeline stalls while busy is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per operation, one bit per cycle; equals XLEN.

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  input  32  rs1 operand (register-file r_data1)
- op_b  input  32  rs2 operand (register-file r_data2)
- rd_in  input  5  destination register index
- kill  input  1  pipeline flush; aborts the in-flight operation
- busy  output  1  high in BUSY and DONE states
- done  output  1  one-cycle result-valid pulse
- result  output  32  operation result; valid when done=1
- rd_out  output  5  destination index latched at accept
- wb_enable  output  1  done && (rd_out != 0); drives the register-file write enable

Behaviour:
- Reset: state=IDLE; busy, done, wb_enable, result, rd_out all 0; internal accumulators and counter cleared. Reset wins over every other input, including mid-operation: no done is produced for an aborted operation.
- FSM states are IDLE, BUSY, DONE.
- IDLE -> BUSY when start=1 && kill=0. At the accepting edge:
  - latch op and rd_in;
  - latch |op_a| and |op_b| as magnitudes per the operand signedness of op;
  - record result-sign flags;
  - load counter=ITER.
- BUSY: one iteration per cycle, then counter decrements.
  - Multiply: radix-2 shift-add on magnitudes, 64-bit product.
  - Divide: restoring division, 32-bit quotient and remainder.
  - When counter reaches 0 -> DONE.
- DONE: done=1 for exactly one cycle. result, rd_out and wb_enable are valid in the same cycle. Next state is IDLE unconditionally.
- Latency: done is high in the cycle following the 33rd rising edge after the accepting edge. The latency is the same for every op and every operand value, including special cases.
- start while busy=1 is ignored, with no queuing; the upstream stage must hold the instruction until done.
- kill=1 in BUSY or DONE -> IDLE at the next edge. done and wb_enable are forced low in the kill cycle. kill in IDLE with start=1 suppresses the accept.
- Sign rules:
  - MULH: signed x signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV/REM: signed.
  - Final negation is applied combinationally when entering DONE.
  - MUL returns product[31:0]; MULH* return product[63:32].
- Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
- Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
- result holds its value after done until the next accept; only the done cycle is architecturally meaningful.
- wb_enable is never asserted for rd_out=0, so x0 stays zero.

Decomposition:
- Shared package muldiv_pkg holds:
  - op_e enum with the eight funct3 encodings;
  - state_e {IDLE, BUSY, DONE};
  - constants XLEN=32 and MULDIV_LATENCY=33;
  - helper functions is_div(op) and a_signed(op)/b_signed(op).
- One sub-module: muldiv_iter_core.
  - Contains the per-cycle shift-add/restore datapath on magnitudes.
  - Inputs: load, step, mode.
  - Outputs: hi/lo accumulators.
- The top level owns the FSM, counter, sign handling, special cases and handshake.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) with rd_in=5 -> done exactly 33 edges after accept, result=0xFFFFFFEB, rd_out=5, wb_enable=1. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. Latency is still 33 in all these cases.
- MUL 3x4 with rd_in=0 -> done=1, result=12, wb_enable=0.
- Start MUL 3x4, then pulse start with DIV operands at cycles 5 and 20 -> both pulses ignored, a single done with result 12, busy continuously high until done.
- Kill at cycle 10 of BUSY -> IDLE next edge, no done ever. Then reset asserted mid-operation of a new MUL -> all outputs 0, no done. A start immediately after each abort is accepted and completes correctly.
